// File: rtl/bus_ram_responder.sv
// Single-port word RAM behind a cyc/ack bus target with byte lanes
// and a fixed number of wait states before the registered ack.
module bus_ram_responder #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bus_cyc_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_adr_i,
    input  logic [3:0]  bus_sel_i,
    input  logic [31:0] bus_dat_i,
    output logic [31:0] bus_dat_o,
    output logic        bus_ack_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_END
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;

    logic          req_we;
    logic [AW-1:0] req_idx;
    logic [3:0]    req_sel;
    logic [31:0]   req_dat;
    logic [31:0]   cur_word;
    logic [31:0]   new_word;
    logic          latch;
    logic          enter_ack;

    logic [31:0] ram [2**AW];

    logic unused_adr;
    assign unused_adr = ^{bus_adr_i[31:AW+2], bus_adr_i[1:0]};

    // With zero wait states the ack edge is also the latch edge,
    // so the request is taken straight from the bus while idle.
    always_comb begin
        req_we  = we_q;
        req_idx = idx_q;
        req_sel = sel_q;
        req_dat = dat_q;
        if (state_q == S_IDLE) begin
            req_we  = bus_we_i;
            req_idx = bus_adr_i[AW+1:2];
            req_sel = bus_sel_i;
            req_dat = bus_dat_i;
        end
    end

    always_comb begin
        cur_word = ram[req_idx];
        new_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (req_we && req_sel[i]) begin
                new_word[8*i +: 8] = req_dat[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        enter_ack = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus_cyc_i) begin
                    latch = 1'b1;
                    cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d   = S_ACK;
                    enter_ack = 1'b1;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_END;
            end
            S_END: begin
                if (!bus_cyc_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            bus_ack_o <= 1'b0;
            bus_dat_o <= 32'd0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            sel_q     <= 4'd0;
            dat_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_ack_o <= enter_ack;
            if (enter_ack) begin
                bus_dat_o <= new_word;
            end
            if (latch) begin
                we_q  <= bus_we_i;
                idx_q <= bus_adr_i[AW+1:2];
                sel_q <= bus_sel_i;
                dat_q <= bus_dat_i;
            end
        end
    end

    // RAM is not reset; rst_ni gating keeps an aborted cycle from committing.
    always_ff @(posedge clk_i) begin
        if (rst_ni && enter_ack && req_we) begin
            ram[req_idx] <= new_word;
        end
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench: three responders (0 waits, 3 waits, AW=4 wrap)
// driven one transaction at a time with hand-computed expectations.
module tb_bus_ram_responder;

    logic        clk;
    logic        rst_n;
    logic        cyc  [3];
    logic        we   [3];
    logic [31:0] adr  [3];
    logic [3:0]  sel  [3];
    logic [31:0] wdat [3];
    logic [31:0] rdat [3];
    logic        ack  [3];

    int passed;
    int total;

    bus_ram_responder #(.AW(10), .WAIT_STATES(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n),
        .bus_cyc_i(cyc[0]), .bus_we_i(we[0]), .bus_adr_i(adr[0]),
        .bus_sel_i(sel[0]), .bus_dat_i(wdat[0]),
        .bus_dat_o(rdat[0]), .bus_ack_o(ack[0])
    );

    bus_ram_responder #(.AW(10), .WAIT_STATES(3)) u3 (
        .clk_i(clk), .rst_ni(rst_n),
        .bus_cyc_i(cyc[1]), .bus_we_i(we[1]), .bus_adr_i(adr[1]),
        .bus_sel_i(sel[1]), .bus_dat_i(wdat[1]),
        .bus_dat_o(rdat[1]), .bus_ack_o(ack[1])
    );

    bus_ram_responder #(.AW(4), .WAIT_STATES(0)) u4 (
        .clk_i(clk), .rst_ni(rst_n),
        .bus_cyc_i(cyc[2]), .bus_we_i(we[2]), .bus_adr_i(adr[2]),
        .bus_sel_i(sel[2]), .bus_dat_i(wdat[2]),
        .bus_dat_o(rdat[2]), .bus_ack_o(ack[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Cycle 0 is the cycle cyc is first high; lat is the ack cycle.
    task automatic xact(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        input int hold, output int lat,
                        output logic [31:0] rd, output int extra);
        lat   = -1;
        rd    = 32'hx;
        extra = 0;
        @(negedge clk);
        cyc[k]  = 1'b1;
        we[k]   = w;
        adr[k]  = a;
        sel[k]  = s;
        wdat[k] = d;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (ack[k]) begin
                lat = c;
                rd  = rdat[k];
                break;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            if (ack[k]) extra++;
        end
        @(negedge clk);
        cyc[k]  = 1'b0;
        wdat[k] = 32'h0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int          lat;
        int          extra;
        logic [31:0] rd;

        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc[k]  = 1'b0;
            we[k]   = 1'b0;
            adr[k]  = 32'h0;
            sel[k]  = 4'h0;
            wdat[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", {31'd0, ack[0]}, 32'd0);
        chk("rst_dat0", rdat[0], 32'd0);
        chk("rst_ack3", {31'd0, ack[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        xact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, lat, rd, extra);
        chk("w0_wr_lat", 32'(lat), 32'd1);
        chk("w0_wr_dat", rd, 32'hDEADBEEF);
        xact(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, lat, rd, extra);
        chk("w0_rd_lat", 32'(lat), 32'd1);
        chk("w0_rd_dat", rd, 32'hDEADBEEF);

        xact(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 0, lat, rd, extra);
        xact(0, 1'b1, 32'h20, 4'b0100, 32'hAAAAAAAA, 0, lat, rd, extra);
        chk("lane2_ackdat", rd, 32'h11AA3344);
        xact(0, 1'b0, 32'h22, 4'h0, 32'h0, 0, lat, rd, extra);
        chk("lane2_rd", rd, 32'h11AA3344);
        xact(0, 1'b1, 32'h20, 4'b0011, 32'h0000BEEF, 0, lat, rd, extra);
        xact(0, 1'b0, 32'h20, 4'hF, 32'h0, 0, lat, rd, extra);
        chk("lane10_rd", rd, 32'h11AABEEF);
        xact(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 0, lat, rd, extra);
        chk("sel0_lat", 32'(lat), 32'd1);
        chk("sel0_ackdat", rd, 32'h11AABEEF);
        xact(0, 1'b0, 32'h20, 4'h0, 32'h0, 0, lat, rd, extra);
        chk("sel0_rd", rd, 32'h11AABEEF);

        xact(1, 1'b1, 32'h30, 4'hF, 32'hA5A5A5A5, 0, lat, rd, extra);
        chk("w3_wr_lat", 32'(lat), 32'd4);
        xact(1, 1'b0, 32'h30, 4'h0, 32'h0, 3, lat, rd, extra);
        chk("w3_rd_lat", 32'(lat), 32'd4);
        chk("w3_rd_dat", rd, 32'hA5A5A5A5);
        chk("w3_no_extra", 32'(extra), 32'd0);

        @(negedge clk);
        cyc[1]  = 1'b1;
        we[1]   = 1'b1;
        adr[1]  = 32'h30;
        sel[1]  = 4'hF;
        wdat[1] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc[1] = 1'b0;
        extra  = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (ack[1]) extra++;
        end
        chk("abort_no_ack", 32'(extra), 32'd0);
        xact(1, 1'b0, 32'h30, 4'h0, 32'h0, 0, lat, rd, extra);
        chk("abort_rd", rd, 32'hA5A5A5A5);

        xact(2, 1'b1, 32'h40, 4'hF, 32'h00000055, 0, lat, rd, extra);
        xact(2, 1'b0, 32'h00, 4'h0, 32'h0, 0, lat, rd, extra);
        chk("wrap_rd", rd, 32'h00000055);
        xact(2, 1'b1, 32'h08, 4'hF, 32'hCAFEF00D, 0, lat, rd, extra);
        xact(2, 1'b0, 32'h08, 4'h0, 32'h0, 0, lat, rd, extra);
        chk("b2b_rd", rd, 32'hCAFEF00D);

        xact(1, 1'b1, 32'h34, 4'hF, 32'h12345678, 0, lat, rd, extra);
        chk("pre_rst_dat", rdat[1], 32'h12345678);
        @(negedge clk);
        cyc[1]  = 1'b1;
        we[1]   = 1'b1;
        adr[1]  = 32'h34;
        sel[1]  = 4'hF;
        wdat[1] = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", {31'd0, ack[1]}, 32'd0);
        chk("midrst_dat", rdat[1], 32'd0);
        cyc[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        xact(1, 1'b0, 32'h34, 4'h0, 32'h0, 0, lat, rd, extra);
        chk("midrst_rd", rd, 32'h12345678);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
